drp_pll_responder: RTL and testbench

Synthesizable responder for the 5-bit-address / 16-bit-data dynamic reconfiguration port (DRP) that the PLL controller drives. It stands in for the PLL primitive's DRP side and lock output, so the DRP sequencer and reset/lock chain can be exercised in simulation and on devices without the hard PLL. It sits on CLK, the same clock as the DRP master. It holds a 32 x 16 register file, acknowledges every access after a fixed latency, and models LOCKED from the PLL reset input.

---
 rtl/drp_pkg.sv | 8 +
 rtl/pll_lock_timer.sv | 50 +++++
 rtl/drp_pll_responder.sv | 111 +++++++++++
 tb/tb_drp_pll_responder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/drp_pkg.sv
// Shared DRP widths and FSM state encodings for the PLL DRP responder.
package drp_pkg;
  localparam int DRP_AW = 5;
  localparam int DRP_DW = 16;

  typedef enum logic {IDLE, BUSY} acc_state_t;
  typedef enum logic [1:0] {HOLD, COUNT, LOCK} lock_state_t;
endpackage

// File: rtl/pll_lock_timer.sv
// Models PLL LOCKED: rises LOCK_CYC cycles after RST_PLL is seen low, drops as soon as RST_PLL is seen high.
module pll_lock_timer
  import drp_pkg::*;
#(
  parameter int LOCK_CYC = 64
) (
  input  logic CLK,
  input  logic RSTXO,
  input  logic RST_PLL,
  output logic LOCKED
);

  localparam logic [15:0] LAST_CNT = 16'(LOCK_CYC - 1);

  lock_state_t r_state;
  logic [15:0] r_cnt;
  logic        r_locked;

  always_ff @(posedge CLK or negedge RSTXO) begin
    if (!RSTXO) begin
      r_state  <= HOLD;
      r_cnt    <= '0;
      r_locked <= 1'b0;
    end else if (RST_PLL) begin
      r_state  <= HOLD;
      r_cnt    <= '0;
      r_locked <= 1'b0;
    end else begin
      case (r_state)
        HOLD: r_state <= COUNT;
        COUNT: begin
          if (r_cnt == LAST_CNT) begin
            r_state  <= LOCK;
            r_locked <= 1'b1;
          end else if (r_cnt != 16'hFFFF) begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        LOCK: r_locked <= 1'b1;
        default: begin
          r_state  <= HOLD;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign LOCKED = r_locked;

endmodule

// File: rtl/drp_pll_responder.sv
// DRP responder standing in for a PLL: 32x16 register file, fixed-latency DRDY, modelled LOCKED.
// Define DRP_PLL_RESPONDER_ERR_EN to build the sticky protocol-error (ERR) logic.
module drp_pll_responder
  import drp_pkg::*;
#(
  parameter int ACK_LAT  = 4,
  parameter int LOCK_CYC = 64
) (
  input  logic              CLK,
  input  logic              RSTXO,
  input  logic              DEN,
  input  logic              DWE,
  input  logic [DRP_AW-1:0] DADDR,
  input  logic [DRP_DW-1:0] DI,
  output logic [DRP_DW-1:0] DO,
  output logic              DRDY,
  input  logic              RST_PLL,
  output logic              LOCKED,
  output logic              ERR
);

  localparam logic [3:0] LAT_LOAD = 4'(ACK_LAT - 1);

  acc_state_t        r_state;
  logic [3:0]        r_lat;
  logic              r_we;
  logic [DRP_AW-1:0] r_addr;
  logic [DRP_DW-1:0] r_mem [2**DRP_AW];
  logic [DRP_DW-1:0] r_do;
  logic              r_drdy;
  logic              w_accept;
  logic              w_locked;

  // The DRDY cycle is still part of the access, so a strobe there is refused too.
  assign w_accept = DEN && (r_state == IDLE) && !r_drdy;

  always_ff @(posedge CLK or negedge RSTXO) begin
    if (!RSTXO) begin
      for (int i = 0; i < 2**DRP_AW; i++) r_mem[i] <= '0;
    end else if (w_accept && DWE) begin
      r_mem[DADDR] <= DI;
    end
  end

  always_ff @(posedge CLK or negedge RSTXO) begin
    if (!RSTXO) begin
      r_state <= IDLE;
      r_lat   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_do    <= '0;
      r_drdy  <= 1'b0;
    end else begin
      r_drdy <= 1'b0;
      r_do   <= '0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we   <= DWE;
            r_addr <= DADDR;
            if (ACK_LAT == 1) begin
              r_drdy <= 1'b1;
              if (!DWE) r_do <= r_mem[DADDR];
            end else begin
              r_lat   <= LAT_LOAD;
              r_state <= BUSY;
            end
          end
        end
        BUSY: begin
          r_lat <= r_lat - 4'd1;
          if (r_lat == 4'd1) begin
            r_drdy  <= 1'b1;
            r_state <= IDLE;
            if (!r_we) r_do <= r_mem[r_addr];
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  pll_lock_timer #(.LOCK_CYC(LOCK_CYC)) u_lock (
    .CLK    (CLK),
    .RSTXO  (RSTXO),
    .RST_PLL(RST_PLL),
    .LOCKED (w_locked)
  );

`ifdef DRP_PLL_RESPONDER_ERR_EN
  logic r_err;

  // Sticky: refused strobes and writes into a running (locked, unreset) PLL.
  always_ff @(posedge CLK or negedge RSTXO) begin
    if (!RSTXO) begin
      r_err <= 1'b0;
    end else if ((DEN && !w_accept) || (w_accept && DWE && !RST_PLL && w_locked)) begin
      r_err <= 1'b1;
    end
  end

  assign ERR = r_err;
`else
  assign ERR = 1'b0;
`endif

  assign DO     = r_do;
  assign DRDY   = r_drdy;
  assign LOCKED = w_locked;

endmodule

// File: tb/tb_drp_pll_responder.sv
// Bench: default instance (ACK_LAT=4, LOCK_CYC=64) plus a corner instance (ACK_LAT=1, LOCK_CYC=1).
module tb_drp_pll_responder;

`ifdef DRP_PLL_RESPONDER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rstxo, den, dwe, rst_pll;
  logic [4:0]  daddr [2];
  logic [15:0] di [2];
  logic [15:0] dout [2];
  logic [1:0]  drdy, locked, err;

  int lat [2] = '{4, 1};
  int lkc [2] = '{64, 1};

  drp_pll_responder #(.ACK_LAT(4), .LOCK_CYC(64)) u_a (
    .CLK(clk), .RSTXO(rstxo[0]), .DEN(den[0]), .DWE(dwe[0]), .DADDR(daddr[0]), .DI(di[0]),
    .DO(dout[0]), .DRDY(drdy[0]), .RST_PLL(rst_pll[0]), .LOCKED(locked[0]), .ERR(err[0])
  );

  drp_pll_responder #(.ACK_LAT(1), .LOCK_CYC(1)) u_b (
    .CLK(clk), .RSTXO(rstxo[1]), .DEN(den[1]), .DWE(dwe[1]), .DADDR(daddr[1]), .DI(di[1]),
    .DO(dout[1]), .DRDY(drdy[1]), .RST_PLL(rst_pll[1]), .LOCKED(locked[1]), .ERR(err[1])
  );

  // Reference model: edge numbers, last accepted access, cycles of RST_PLL low.
  logic [15:0] mem [2][32];
  int          edge_n [2], last_acc [2], lowcyc [2];
  bit          pend [2], pend_we [2];
  logic [4:0]  pend_addr [2];
  bit          exp_err [2], exp_drdy [2];
  logic [15:0] exp_do [2];
  int          checks, errors;

  function automatic bit exp_locked(int d);
    return lowcyc[d] > lkc[d];
  endfunction

  task automatic model_reset(int d);
    for (int a = 0; a < 32; a++) mem[d][a] = 16'h0000;
    edge_n[d] = 0; last_acc[d] = -100; lowcyc[d] = 0;
    pend[d] = 0; pend_we[d] = 0; pend_addr[d] = 0;
    exp_err[d] = 0; exp_drdy[d] = 0; exp_do[d] = 16'h0000;
  endtask

  task automatic tick();
    bit pre_lock;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (!rstxo[d]) begin
        model_reset(d);
      end else begin
        pre_lock = exp_locked(d);
        edge_n[d]++;
        exp_drdy[d] = 0;
        exp_do[d] = 16'h0000;
        if (den[d]) begin
          if (edge_n[d] - last_acc[d] <= lat[d]) begin
            if (ERR_EN) exp_err[d] = 1;
          end else begin
            last_acc[d] = edge_n[d];
            pend[d] = 1; pend_we[d] = dwe[d]; pend_addr[d] = daddr[d];
            if (dwe[d]) begin
              if (ERR_EN && pre_lock && !rst_pll[d]) exp_err[d] = 1;
              mem[d][daddr[d]] = di[d];
            end
          end
        end
        if (pend[d] && edge_n[d] == last_acc[d] + lat[d] - 1) begin
          exp_drdy[d] = 1;
          exp_do[d] = pend_we[d] ? 16'h0000 : mem[d][pend_addr[d]];
          pend[d] = 0;
        end
        if (rst_pll[d]) lowcyc[d] = 0;
        else if (lowcyc[d] < 100000) lowcyc[d]++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      checks++; if (dout[d] !== 16'h0000) begin errors++; $display("FAIL reset_do dut%0d: got %h want 0000", d, dout[d]); end
      checks++; if (drdy[d] !== 1'b0) begin errors++; $display("FAIL reset_drdy dut%0d: got %b want 0", d, drdy[d]); end
      checks++; if (locked[d] !== 1'b0) begin errors++; $display("FAIL reset_locked dut%0d: got %b want 0", d, locked[d]); end
      checks++; if (err[d] !== 1'b0) begin errors++; $display("FAIL reset_err dut%0d: got %b want 0", d, err[d]); end
    end
    rstxo = 2'b11;
    tick();
  endtask

  task automatic test_write_read();
    bit         wes [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [4:0] adr [4] = '{5'h0A, 5'h0A, 5'h03, 5'h1F};
    int seen;
    for (int k = 0; k < 4; k++) begin
      seen = -1;
      den[0] = 1; dwe[0] = wes[k]; daddr[0] = adr[k]; di[0] = 16'hBEEF;
      for (int i = 0; i < lat[0] + 2; i++) begin
        tick(); den[0] = 0;
        checks++; if (drdy[0] !== exp_drdy[0]) begin errors++; $display("FAIL wr_rd_drdy op%0d cyc%0d: got %b want %b", k, i, drdy[0], exp_drdy[0]); end
        checks++; if (dout[0] !== exp_do[0]) begin errors++; $display("FAIL wr_rd_do op%0d cyc%0d: got %h want %h", k, i, dout[0], exp_do[0]); end
        if (drdy[0] === 1'b1 && seen < 0) seen = i;
      end
      checks++; if (seen != lat[0] - 1) begin errors++; $display("FAIL wr_rd_latency op%0d: got %0d want %0d", k, seen, lat[0] - 1); end
    end
  endtask

  task automatic test_random_traffic();
    int gap;
    for (int k = 0; k < 24; k++) begin
      den[0] = 1; dwe[0] = 1'($urandom_range(0, 1)); daddr[0] = 5'($urandom_range(0, 31)); di[0] = 16'($urandom);
      gap = lat[0] + 1 + $urandom_range(0, 2);
      for (int i = 0; i < gap; i++) begin
        tick(); den[0] = 0;
        checks++; if (drdy[0] !== exp_drdy[0] || dout[0] !== exp_do[0]) begin
          errors++; $display("FAIL rand_access op%0d cyc%0d: got drdy=%b do=%h want drdy=%b do=%h", k, i, drdy[0], dout[0], exp_drdy[0], exp_do[0]);
        end
      end
    end
    checks++; if (err[0] !== exp_err[0]) begin errors++; $display("FAIL rand_err: got %b want %b", err[0], exp_err[0]); end
  endtask

  task automatic test_lock_sequence();
    int rise;
    rst_pll[0] = 1; tick(); tick();
    checks++; if (locked[0] !== 1'b0) begin errors++; $display("FAIL lock_hold: got %b want 0", locked[0]); end
    for (int p = 0; p < 2; p++) begin
      rst_pll[0] = 0; rise = -1;
      for (int i = 1; i <= lkc[0] + 6; i++) begin
        tick();
        checks++; if (locked[0] !== exp_locked(0)) begin errors++; $display("FAIL lock_track pass%0d cyc%0d: got %b want %b", p, i, locked[0], exp_locked(0)); end
        if (locked[0] === 1'b1 && rise < 0) rise = i;
      end
      checks++; if (rise != lkc[0] + 1) begin errors++; $display("FAIL lock_rise pass%0d: got edge %0d want %0d", p, rise, lkc[0] + 1); end
      rst_pll[0] = 1; tick();
      checks++; if (locked[0] !== 1'b0) begin errors++; $display("FAIL lock_fall pass%0d: got %b want 0", p, locked[0]); end
    end
    rst_pll[0] = 0;
    repeat (lkc[0] + 2) tick();
  endtask

  task automatic test_write_while_locked();
    checks++; if (locked[0] !== 1'b1) begin errors++; $display("FAIL wwl_locked: got %b want 1", locked[0]); end
    for (int k = 0; k < 2; k++) begin
      den[0] = 1; dwe[0] = (k == 0); daddr[0] = 5'h1F; di[0] = 16'h1234;
      for (int i = 0; i < lat[0] + 2; i++) begin
        tick(); den[0] = 0;
        checks++; if (drdy[0] !== exp_drdy[0] || dout[0] !== exp_do[0]) begin
          errors++; $display("FAIL wwl_access op%0d cyc%0d: got drdy=%b do=%h want drdy=%b do=%h", k, i, drdy[0], dout[0], exp_drdy[0], exp_do[0]);
        end
      end
    end
    checks++; if (err[0] !== exp_err[0]) begin errors++; $display("FAIL wwl_err: got %b want %b", err[0], exp_err[0]); end
  endtask

  task automatic test_midaccess_reset();
    den[0] = 1; dwe[0] = 1; daddr[0] = 5'h07; di[0] = 16'hABCD;
    tick(); den[0] = 0; tick();
    rstxo[0] = 0; rst_pll[0] = 1; #1;
    model_reset(0);
    checks++; if (drdy[0] !== 1'b0 || dout[0] !== 16'h0000) begin errors++; $display("FAIL mid_rst_out: got drdy=%b do=%h want 0/0000", drdy[0], dout[0]); end
    checks++; if (locked[0] !== 1'b0 || err[0] !== 1'b0) begin errors++; $display("FAIL mid_rst_flags: got locked=%b err=%b want 0/0", locked[0], err[0]); end
    tick(); tick();
    rstxo[0] = 1;
    for (int i = 0; i < lat[0] + 3; i++) begin
      tick();
      checks++; if (drdy[0] !== exp_drdy[0]) begin errors++; $display("FAIL mid_rst_nodrdy cyc%0d: got %b want %b", i, drdy[0], exp_drdy[0]); end
    end
    den[0] = 1; dwe[0] = 0; daddr[0] = 5'h07;
    for (int i = 0; i < lat[0] + 2; i++) begin
      tick(); den[0] = 0;
      checks++; if (drdy[0] !== exp_drdy[0] || dout[0] !== exp_do[0]) begin
        errors++; $display("FAIL mid_rst_read cyc%0d: got drdy=%b do=%h want drdy=%b do=%h", i, drdy[0], dout[0], exp_drdy[0], exp_do[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int nrdy = 0;
    checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL b2b_err_before: got %b want 0", err[0]); end
    for (int i = 0; i < lat[0] + 6; i++) begin
      den[0] = (i == 0 || i == 2); dwe[0] = 1; daddr[0] = 5'h02; di[0] = (i == 0) ? 16'h1111 : 16'h2222;
      tick(); den[0] = 0;
      checks++; if (drdy[0] !== exp_drdy[0]) begin errors++; $display("FAIL b2b_drdy cyc%0d: got %b want %b", i, drdy[0], exp_drdy[0]); end
      if (drdy[0] === 1'b1) nrdy++;
    end
    checks++; if (nrdy != 1) begin errors++; $display("FAIL b2b_drdy_count: got %0d want 1", nrdy); end
    den[0] = 1; dwe[0] = 0; daddr[0] = 5'h02;
    for (int i = 0; i < lat[0] + 2; i++) begin
      tick(); den[0] = 0;
      checks++; if (dout[0] !== exp_do[0]) begin errors++; $display("FAIL b2b_read cyc%0d: got %h want %h", i, dout[0], exp_do[0]); end
    end
    checks++; if (err[0] !== exp_err[0]) begin errors++; $display("FAIL b2b_err: got %b want %b", err[0], exp_err[0]); end
  endtask

  task automatic test_rst_pll_toggle();
    int seen;
    for (int k = 0; k < 2; k++) begin
      seen = -1;
      den[0] = 1; dwe[0] = (k == 0); daddr[0] = 5'h11; di[0] = 16'h5A5A;
      for (int i = 0; i < lat[0] + 2; i++) begin
        tick(); den[0] = 0; rst_pll[0] = 1'($urandom_range(0, 1));
        checks++; if (drdy[0] !== exp_drdy[0] || dout[0] !== exp_do[0] || locked[0] !== exp_locked(0)) begin
          errors++; $display("FAIL toggle_access op%0d cyc%0d: got drdy=%b do=%h lk=%b want drdy=%b do=%h lk=%b",
                             k, i, drdy[0], dout[0], locked[0], exp_drdy[0], exp_do[0], exp_locked(0));
        end
        if (drdy[0] === 1'b1 && seen < 0) seen = i;
      end
      checks++; if (seen != lat[0] - 1) begin errors++; $display("FAIL toggle_latency op%0d: got %0d want %0d", k, seen, lat[0] - 1); end
    end
    rst_pll[0] = 1;
  endtask

  task automatic test_corner();
    int   rise = -1;
    bit   c_den [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    bit   c_we  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    rst_pll[1] = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if (locked[1] !== exp_locked(1)) begin errors++; $display("FAIL corner_lock cyc%0d: got %b want %b", i, locked[1], exp_locked(1)); end
      if (locked[1] === 1'b1 && rise < 0) rise = i;
    end
    checks++; if (rise != lkc[1] + 1) begin errors++; $display("FAIL corner_lock_rise: got edge %0d want %0d", rise, lkc[1] + 1); end
    for (int i = 0; i < 6; i++) begin
      den[1] = c_den[i]; dwe[1] = c_we[i]; daddr[1] = 5'h04; di[1] = 16'hC0DE;
      tick(); den[1] = 0;
      checks++; if (drdy[1] !== exp_drdy[1] || dout[1] !== exp_do[1]) begin
        errors++; $display("FAIL corner_access cyc%0d: got drdy=%b do=%h want drdy=%b do=%h", i, drdy[1], dout[1], exp_drdy[1], exp_do[1]);
      end
    end
    checks++; if (err[1] !== exp_err[1]) begin errors++; $display("FAIL corner_err: got %b want %b", err[1], exp_err[1]); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rstxo = 2'b00; den = 2'b00; dwe = 2'b00; rst_pll = 2'b11;
    for (int d = 0; d < 2; d++) begin
      daddr[d] = 5'h00; di[d] = 16'h0000;
      model_reset(d);
    end
    test_reset();
    test_write_read();
    test_random_traffic();
    test_lock_sequence();
    test_write_while_locked();
    test_midaccess_reset();
    test_back_to_back();
    test_rst_pll_toggle();
    test_corner();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
